// File: rtl/idsm_seq_pkg.sv
//------------------------------------------------------------------------------
// Module      : idsm_seq_pkg
// Description : Shared types and helpers for the incremental delta-sigma
//               conversion sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package idsm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } seq_state_t;

    localparam int unsigned c_osr_min_default = 2;

    // Conversion length never drops below the minimum the filter can settle in.
    function automatic logic [31:0] clamp_osr(input logic [31:0] cfg,
                                              input logic [31:0] min_val);
        return (cfg < min_val) ? min_val : cfg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_cycle_counter.sv
//------------------------------------------------------------------------------
// Module      : seq_cycle_counter
// Description : Loadable down-counter with terminal-count flag (count == 1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_cycle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count > CNT_W'(1))) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign tc = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/idsm_conversion_sequencer.sv
//------------------------------------------------------------------------------
// Module      : idsm_conversion_sequencer
// Description : Sequences clear/accumulate/capture phases of incremental
//               delta-sigma conversions and presents results on valid/ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module idsm_conversion_sequencer
    import idsm_seq_pkg::*;
#(
    parameter int DATA_BITS    = 16,
    parameter int CNT_W        = 8,
    parameter int RESET_CYCLES = 2,
    parameter int OSR_MIN      = c_osr_min_default
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     osr_cfg,
    input  logic [DATA_BITS-1:0] filt_data,
    output logic                 mod_reset,
    output logic                 filt_clear,
    output logic                 filt_en,
    output logic [DATA_BITS-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic [CNT_W-1:0]     conv_count
);

    localparam logic [CNT_W-1:0] c_reset_cycles = CNT_W'(RESET_CYCLES);

    seq_state_t           r_state;
    logic [CNT_W-1:0]     r_n;
    logic                 r_mod_reset;
    logic                 r_filt_clear;
    logic                 r_filt_en;
    logic [DATA_BITS-1:0] r_result;
    logic                 r_result_valid;
    logic                 r_busy;
    logic                 r_overrun;
    logic [CNT_W-1:0]     r_conv_count;

    logic                 w_tc;
    logic                 w_cnt_load;
    logic [CNT_W-1:0]     w_cnt_load_val;
    logic                 w_cnt_dec;
    logic                 w_capture;
    logic [CNT_W-1:0]     w_n_clamped;

    assign w_n_clamped = CNT_W'(clamp_osr(32'(osr_cfg), 32'(OSR_MIN)));
    assign w_capture   = (r_state == ST_CAPTURE) && !abort;
    assign w_cnt_dec   = (r_state == ST_CLEAR) || (r_state == ST_RUN);

    // Counter reloads on entry to CLEAR (reset duration) and RUN (N).
    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (start || continuous) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_reset_cycles;
                end
            end
            ST_CLEAR: begin
                if (w_tc) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = r_n;
                end
            end
            ST_CAPTURE: begin
                if (continuous) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_reset_cycles;
                end
            end
            default: ;
        endcase
    end

    seq_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_cnt_load),
        .load_value (w_cnt_load_val),
        .dec        (w_cnt_dec),
        .tc         (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_n            <= CNT_W'(OSR_MIN);
            r_mod_reset    <= 1'b1;
            r_filt_clear   <= 1'b0;
            r_filt_en      <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_conv_count   <= '0;
        end else begin
            // A capture at the accept edge keeps valid high with fresh data.
            if (w_capture) begin
                r_result       <= filt_data;
                r_result_valid <= 1'b1;
                r_conv_count   <= r_conv_count + CNT_W'(1);
                if (r_result_valid && !result_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_result_valid && result_ready) begin
                r_result_valid <= 1'b0;
            end

            if (abort && (r_state != ST_IDLE)) begin
                r_state      <= ST_IDLE;
                r_mod_reset  <= 1'b1;
                r_filt_clear <= 1'b0;
                r_filt_en    <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start || continuous) begin
                            r_state      <= ST_CLEAR;
                            r_n          <= w_n_clamped;
                            r_overrun    <= 1'b0;
                            r_mod_reset  <= 1'b1;
                            r_filt_clear <= 1'b1;
                            r_filt_en    <= 1'b0;
                            r_busy       <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        if (w_tc) begin
                            r_state      <= ST_RUN;
                            r_mod_reset  <= 1'b0;
                            r_filt_clear <= 1'b0;
                            r_filt_en    <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_tc) begin
                            r_state      <= ST_CAPTURE;
                            r_mod_reset  <= 1'b1;
                            r_filt_clear <= 1'b0;
                            r_filt_en    <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (continuous) begin
                            r_state      <= ST_CLEAR;
                            r_n          <= w_n_clamped;
                            r_mod_reset  <= 1'b1;
                            r_filt_clear <= 1'b1;
                            r_filt_en    <= 1'b0;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_mod_reset  <= 1'b1;
                            r_filt_clear <= 1'b0;
                            r_filt_en    <= 1'b0;
                            r_busy       <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mod_reset    = r_mod_reset;
    assign filt_clear   = r_filt_clear;
    assign filt_en      = r_filt_en;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;
    assign conv_count   = r_conv_count;

endmodule

`default_nettype wire

// File: tb/tb_idsm_conversion_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_idsm_conversion_sequencer
// Description : Self-checking bench for idsm_conversion_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_idsm_conversion_sequencer;

    localparam int c_rc = 2;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        start        = 1'b0;
    logic        continuous   = 1'b0;
    logic        abort        = 1'b0;
    logic        result_ready = 1'b0;
    logic [7:0]  osr_cfg      = 8'd0;
    logic [15:0] filt_data    = 16'd11;
    logic        mod_reset, filt_clear, filt_en, result_valid, busy, overrun;
    logic [15:0] result;
    logic [7:0]  conv_count;

    idsm_conversion_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .osr_cfg      (osr_cfg),
        .filt_data    (filt_data),
        .mod_reset    (mod_reset),
        .filt_clear   (filt_clear),
        .filt_en      (filt_en),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun),
        .conv_count   (conv_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fval(input int k);
        return 16'(k * 37 + 11);
    endfunction

    // During the cycle after edge k, filt_data = fval(k).
    int edge_no = 0;
    always @(posedge clk) begin
        edge_no   <= edge_no + 1;
        filt_data <= fval(edge_no + 1);
    end

    typedef struct {
        int          at_edge;
        logic [15:0] res;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct {
        logic [7:0] osr;
        int         n;
    } vec_t;

    exp_t       sb[$];
    int         total   = 0;
    int         bad     = 0;
    int         en_cnt  = 0;
    int         exp_cnt = 0;
    logic [7:0] prev_count = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic push_exp(input int at);
        exp_t e;
        exp_cnt++;
        e.at_edge = at;
        e.res     = fval(at - 1);
        e.cnt     = 8'(exp_cnt);
        sb.push_back(e);
    endtask

    task automatic wait_count(input logic [7:0] target, input int budget, input string name);
        int i = 0;
        while (conv_count !== target && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (conv_count !== target) begin
            total++;
            bad++;
            $display("FAIL %s timeout: conv_count=%0d wanted %0d", name, conv_count, target);
        end
    endtask

    // Scoreboard: every conv_count step is a capture that must match the queue head.
    always @(negedge clk) begin
        if (filt_en) en_cnt++;
        if (rst_n && conv_count !== prev_count) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_capture: conv_count=%0d at edge %0d", conv_count, edge_no);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cap_edge",   32'(edge_no),    32'(e.at_edge));
                check("cap_result", 32'(result),     32'(e.res));
                check("cap_count",  32'(conv_count), 32'(e.cnt));
                check("cap_valid",  32'(result_valid), 32'd1);
            end
        end
        prev_count = conv_count;
    end

    initial begin
        vec_t       vecs[6];
        int         e0;
        int         c2;
        logic [7:0] saved;

        vecs[0] = '{8'd16, 16};
        vecs[1] = '{8'd0,  2};
        vecs[2] = '{8'd1,  2};
        vecs[3] = '{8'd2,  2};
        vecs[4] = '{8'd3,  3};
        vecs[5] = '{8'd9,  9};

        @(negedge clk);
        check("rst_mod_reset",  32'(mod_reset),    32'd1);
        check("rst_filt_clear", 32'(filt_clear),   32'd0);
        check("rst_filt_en",    32'(filt_en),      32'd0);
        check("rst_result",     32'(result),       32'd0);
        check("rst_valid",      32'(result_valid), 32'd0);
        check("rst_busy",       32'(busy),         32'd0);
        check("rst_overrun",    32'(overrun),      32'd0);
        check("rst_count",      32'(conv_count),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-shot conversions, including clamp of short lengths.
        foreach (vecs[i]) begin
            osr_cfg = vecs[i].osr;
            start   = 1'b1;
            e0      = edge_no + 1;
            en_cnt  = 0;
            push_exp(e0 + c_rc + vecs[i].n + 1);
            @(negedge clk);
            start = 1'b0;
            check("busy_after_start", 32'(busy), 32'd1);
            wait_count(8'(exp_cnt), 400, "single_shot");
            check("en_cycles",   32'(en_cnt),       32'(vecs[i].n));
            check("busy_done",   32'(busy),         32'd0);
            check("valid_done",  32'(result_valid), 32'd1);
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            check("valid_accepted", 32'(result_valid), 32'd0);
        end

        // Continuous with no consumer: second capture overruns.
        osr_cfg    = 8'd4;
        continuous = 1'b1;
        e0         = edge_no + 1;
        push_exp(e0 + 7);
        push_exp(e0 + 14);
        c2 = e0 + 14;
        wait_count(8'(exp_cnt - 1), 50, "cont_first");
        continuous = 1'b0;
        check("cont1_overrun", 32'(overrun),      32'd0);
        check("cont1_valid",   32'(result_valid), 32'd1);
        wait_count(8'(exp_cnt), 50, "cont_second");
        check("cont2_overrun", 32'(overrun),      32'd1);
        check("cont2_busy",    32'(busy),         32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_result", 32'(result),       32'(fval(c2 - 1)));
            check("hold_valid",  32'(result_valid), 32'd1);
        end
        start = 1'b1;
        e0    = edge_no + 1;
        push_exp(e0 + 7);
        @(negedge clk);
        start = 1'b0;
        check("overrun_cleared", 32'(overrun),      32'd0);
        check("pending_kept",    32'(result_valid), 32'd1);
        result_ready = 1'b1;
        @(negedge clk);
        check("drained", 32'(result_valid), 32'd0);
        wait_count(8'(exp_cnt), 50, "restart");
        check("restart_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        check("restart_accept", 32'(result_valid), 32'd0);
        result_ready = 1'b0;

        // Accept and capture on the same edge.
        continuous = 1'b1;
        e0         = edge_no + 1;
        push_exp(e0 + 7);
        push_exp(e0 + 14);
        c2 = e0 + 14;
        wait_count(8'(exp_cnt - 1), 50, "simul_first");
        continuous = 1'b0;
        while (edge_no < c2 - 1) @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("simul_valid",   32'(result_valid), 32'd1);
        check("simul_overrun", 32'(overrun),      32'd0);
        check("simul_count",   32'(conv_count),   32'(8'(exp_cnt)));
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;

        // Abort in RUN cycle 5; a start during RUN must be ignored.
        saved   = conv_count;
        osr_cfg = 8'd16;
        start   = 1'b1;
        e0      = edge_no + 1;
        en_cnt  = 0;
        @(negedge clk);
        start = 1'b0;
        while (edge_no < e0 + 3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (edge_no < e0 + 6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",      32'(busy),         32'd0);
        check("abort_mod_reset", 32'(mod_reset),    32'd1);
        check("abort_filt_en",   32'(filt_en),      32'd0);
        check("abort_count",     32'(conv_count),   32'(saved));
        check("abort_valid",     32'(result_valid), 32'd0);
        check("abort_en_cycles", 32'(en_cnt),       32'd5);
        repeat (30) @(negedge clk);
        check("no_queued_start", 32'(busy),       32'd0);
        check("abort_count_end", 32'(conv_count), 32'(saved));

        // Asynchronous reset mid-RUN, checked between clock edges.
        start = 1'b1;
        e0    = edge_no + 1;
        @(negedge clk);
        start = 1'b0;
        while (edge_no < e0 + 5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_mod_reset",  32'(mod_reset),    32'd1);
        check("arst_filt_clear", 32'(filt_clear),   32'd0);
        check("arst_filt_en",    32'(filt_en),      32'd0);
        check("arst_result",     32'(result),       32'd0);
        check("arst_valid",      32'(result_valid), 32'd0);
        check("arst_busy",       32'(busy),         32'd0);
        check("arst_overrun",    32'(overrun),      32'd0);
        check("arst_count",      32'(conv_count),   32'd0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 256 back-to-back minimum-length conversions wrap the counter.
        result_ready = 1'b1;
        osr_cfg      = 8'd0;
        continuous   = 1'b1;
        e0           = edge_no + 1;
        for (int k = 1; k <= 256; k++) push_exp(e0 + 5 * k);
        wait_count(8'd255, 1400, "wrap_255");
        continuous = 1'b0;
        wait_count(8'd0, 20, "wrap_0");
        check("wrap_count",   32'(conv_count), 32'd0);
        check("wrap_busy",    32'(busy),       32'd0);
        check("wrap_overrun", 32'(overrun),    32'd0);
        result_ready = 1'b0;
        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/idsm_conversion_sequencer.md
Name: idsm_conversion_sequencer

Overview:
- Sequences incremental delta-sigma conversions around the decimation filter datapath.
- Per conversion: holds the modulator and filter in reset, enables accumulation for a programmable number of modulator clocks, then captures the filter output.
- Presents the captured result on a valid/ready interface to the readout logic.
- Supports single-shot and continuous (back-to-back) operation, with abort and overrun reporting.

Parameters:
- DATA_BITS, 16, width of filter output and result.
- CNT_W, 8, width of the conversion-length configuration and counters.
- RESET_CYCLES, 2, number of clocks the modulator and filter are held cleared before each conversion (valid range 1..15).
- OSR_MIN, 2, minimum conversion length; smaller osr_cfg values are clamped to this.

Ports:
- clk  in  1  system clock (also the modulator sample clock).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one conversion; sampled only in IDLE.
- continuous  in  1  when 1, start conversions back-to-back without start.
- abort  in  1  terminate any conversion; return to IDLE.
- osr_cfg  in  CNT_W  conversion length N in clocks; latched when leaving IDLE.
- filt_data  in  DATA_BITS  filter integrator output (second-stage accumulator).
- mod_reset  out  1  active-high modulator integrator reset.
- filt_clear  out  1  active-high clear of filter accumulators.
- filt_en  out  1  filter accumulate enable.
- result  out  DATA_BITS  captured conversion result.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky: an unconsumed result was overwritten.
- conv_count  out  CNT_W  completed conversions, wraps 2^CNT_W-1 -> 0.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, mod_reset=1, filt_clear=0, filt_en=0, result=0, result_valid=0, busy=0, overrun=0, conv_count=0.
- States: IDLE, CLEAR, RUN, CAPTURE.
- IDLE:
  - Outputs: mod_reset=1, filt_clear=0, filt_en=0.
  - Transition: start=1 or continuous=1 -> CLEAR.
  - On that transition: latch N = max(osr_cfg, OSR_MIN) and clear overrun.
- CLEAR:
  - Outputs: mod_reset=1, filt_clear=1, filt_en=0.
  - Lasts exactly RESET_CYCLES clocks, then -> RUN.
- RUN:
  - Outputs: mod_reset=0, filt_clear=0, filt_en=1.
  - Lasts exactly N clocks, then -> CAPTURE.
- CAPTURE (one clock):
  - Outputs: mod_reset=1, filt_en=0.
  - At the end of the clock: result <= filt_data, result_valid <= 1, conv_count increments.
  - If continuous=1 -> CLEAR, re-latching N from osr_cfg. Otherwise -> IDLE.
- Latency: if start is sampled at edge e0, filt_en is high for exactly N cycles and result_valid rises at edge e0+RESET_CYCLES+N+1.
- Handshake:
  - result_valid=1 and result_ready=1 at an edge -> result_valid=0 after that edge, unless a capture occurs at the same edge.
  - result and result_valid are stable while result_valid=1 and result_ready=0.
- Overwrite:
  - Capture while result_valid=1 and result_ready=0: result is overwritten, result_valid stays 1, overrun <= 1.
  - Capture and accept at the same edge: new result, result_valid stays 1, no overrun.
- abort=1 in any non-IDLE state -> IDLE at the next edge. No capture occurs and conv_count is unchanged. abort has priority over every other transition. A pending result_valid is preserved.
- start is ignored while busy, and is not queued.
- continuous falling during CLEAR or RUN: the current conversion completes and captures, then the block goes to IDLE.
- osr_cfg changes take effect only at the next latch point.
- Counters:
  - Cycle counter is CNT_W bits wide.
  - RESET_CYCLES uses the same counter.
  - The counter loads on state entry and counts down to 1.

Decomposition:
- Package idsm_seq_pkg:
  - state enum (IDLE, CLEAR, RUN, CAPTURE);
  - OSR_MIN default;
  - the helper that clamps osr_cfg.
- Sub-module seq_cycle_counter: loadable down-counter with a terminal-count flag, used for both CLEAR and RUN durations.

Test Plan:
- Single shot: osr_cfg=16, RESET_CYCLES=2, filt_data ramps, start pulse at edge 0 -> filt_en high 16 cycles, result_valid rises at edge 19 with result=filt_data of cycle 18, conv_count=1, busy low from edge 19.
- Clamp: osr_cfg=0 and osr_cfg=1 -> filt_en high exactly 2 cycles each.
- Continuous with result_ready=0: continuous=1, N=4 -> second capture sets overrun=1, result holds the second value, result_valid stays 1. The next start from IDLE clears overrun.
- Simultaneous accept and capture: result_ready=1 on the capture edge of conversion 2 -> result_valid stays 1, overrun=0.
- Abort mid-RUN (cycle 5 of 16) -> IDLE next edge, mod_reset=1, conv_count unchanged, no result_valid. start during RUN is ignored.
- Async reset mid-RUN: rst_n low -> all outputs at their reset values immediately, without waiting for a clock edge. After release, conv_count wraps from 255 to 0 after 256 conversions.
